dpram_access_ctrl: RTL and testbench

Front-end controller that sits directly upstream of `dual_port_ram` and drives its A and B ports from two independent valid/ready request streams. It serialises same-address hazards between the ports (write/write, write/read) with round-robin priority, turns the RAM's one-cycle read data into a registered response stream, and counts collisions for debug. Read/read to the same address is never stalled.

---
 rtl/dpram_ctrl_pkg.sv | 23 ++
 rtl/dpram_rsp_pipe.sv | 44 ++++
 rtl/dpram_access_ctrl.sv | 121 ++++++++++++
 tb/tb_dpram_access_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_ctrl_pkg.sv
// Shared constants and types for the dual-port RAM access controller.
// Pure declarations: no logic, no latency.
// Backpressure is handled in the controller, not here.
package dpram_ctrl_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int CNT_W_DEF = 16;

  // One request as seen at a port, at the default widths.
  typedef struct packed {
    logic                we;
    logic [AW_DEF-1:0]   addr;
    logic [DW_DEF-1:0]   wdata;
  } req_t;

  // Which port wins the next same-address hazard.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

endpackage

// File: rtl/dpram_rsp_pipe.sv
// Per-port read response stage: pending tag plus capture of RAM read data.
// Latency: response valid 2 clocks after the read is accepted (1 RAM + 1 capture).
// No backpressure: the response is a single-cycle pulse that must be taken.
module dpram_rsp_pipe
  import dpram_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rd_acc_i,
  input  logic [DW-1:0] ram_dout_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o
);

  logic          pend_q, pend_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Tag follows the RAM read by one cycle; data is captured only when the tag says it is ours.
  always_comb begin
    pend_d  = rd_acc_i;
    valid_d = pend_q;
    rdata_d = pend_q ? ram_dout_i : rdata_q;
  end

  // State registers; reset drops any read that is still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: rtl/dpram_access_ctrl.sv
// Two-port request front end for a dual-port RAM with same-address hazard arbitration.
// Latency: requests reach the RAM combinationally; read responses 2 clocks after accept.
// Backpressure: loser of a write hazard is held off one cycle; round-robin priority.
module dpram_access_ctrl
  import dpram_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a_valid,
  output logic             req_a_ready,
  input  logic             req_a_we,
  input  logic [AW-1:0]    req_a_addr,
  input  logic [DW-1:0]    req_a_wdata,
  input  logic             req_b_valid,
  output logic             req_b_ready,
  input  logic             req_b_we,
  input  logic [AW-1:0]    req_b_addr,
  input  logic [DW-1:0]    req_b_wdata,
  output logic             rsp_a_valid,
  output logic [DW-1:0]    rsp_a_rdata,
  output logic             rsp_b_valid,
  output logic [DW-1:0]    rsp_b_rdata,
  output logic             ram_we_a,
  output logic             ram_we_b,
  output logic             ram_re_a,
  output logic             ram_re_b,
  output logic [AW-1:0]    ram_addr_a,
  output logic [AW-1:0]    ram_addr_b,
  output logic [DW-1:0]    ram_din_a,
  output logic [DW-1:0]    ram_din_b,
  input  logic [DW-1:0]    ram_dout_a,
  input  logic [DW-1:0]    ram_dout_b,
  output logic [CNT_W-1:0] collision_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             collision;
  prio_e            prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_a, acc_b;

  // Same-address hazard: both present, same address, at least one write (read/read is harmless).
  always_comb begin
    collision = req_a_valid && req_b_valid &&
                (req_a_addr == req_b_addr) && (req_a_we || req_b_we);
  end

  // Ready generation: both ports pass freely unless a hazard exists, then only the priority port.
  always_comb begin
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    if (rst) begin
      req_a_ready = !collision || (prio_q == PRIO_A);
      req_b_ready = !collision || (prio_q == PRIO_B);
    end
  end

  // RAM enables follow accepted requests only.
  always_comb begin
    acc_a    = req_a_valid && req_a_ready;
    acc_b    = req_b_valid && req_b_ready;
    ram_we_a = acc_a &&  req_a_we;
    ram_re_a = acc_a && !req_a_we;
    ram_we_b = acc_b &&  req_b_we;
    ram_re_b = acc_b && !req_b_we;
  end

  assign ram_addr_a = req_a_addr;
  assign ram_addr_b = req_b_addr;
  assign ram_din_a  = req_a_wdata;
  assign ram_din_b  = req_b_wdata;

  // Priority flips after each resolved hazard; counter saturates instead of wrapping.
  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (collision) begin
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Arbitration and debug state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= PRIO_A;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

  assign collision_cnt = cnt_q;

  dpram_rsp_pipe #(.DW(DW)) u_rsp_a (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rd_acc_i    (ram_re_a),
    .ram_dout_i  (ram_dout_a),
    .rsp_valid_o (rsp_a_valid),
    .rsp_rdata_o (rsp_a_rdata)
  );

  dpram_rsp_pipe #(.DW(DW)) u_rsp_b (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rd_acc_i    (ram_re_b),
    .ram_dout_i  (ram_dout_b),
    .rsp_valid_o (rsp_b_valid),
    .rsp_rdata_o (rsp_b_rdata)
  );

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Testbench for dpram_access_ctrl with a behavioural dual-port RAM behind it.
// Vectors are applied once per cycle; read responses are checked against a queue.
// Responses have no backpressure, so the monitor takes every pulse as it appears.
module tb_dpram_access_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          req_a_valid, req_a_ready, req_a_we;
  logic [AW-1:0] req_a_addr;
  logic [DW-1:0] req_a_wdata;
  logic          req_b_valid, req_b_ready, req_b_we;
  logic [AW-1:0] req_b_addr;
  logic [DW-1:0] req_b_wdata;
  logic          rsp_a_valid, rsp_b_valid;
  logic [DW-1:0] rsp_a_rdata, rsp_b_rdata;
  logic          ram_we_a, ram_we_b, ram_re_a, ram_re_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;
  logic [DW-1:0] ram_dout_a, ram_dout_b;
  logic [CW-1:0] collision_cnt;

  dpram_access_ctrl #(.DW(DW), .AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_rdata(rsp_a_rdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_rdata(rsp_b_rdata),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b), .ram_re_a(ram_re_a), .ram_re_b(ram_re_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
    .collision_cnt(collision_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: write commits at the edge, read data registered at the edge.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    if (ram_re_a) ram_dout_a <= mem[ram_addr_a];
    if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t q [2][$];

  logic [DW-1:0] ref_mem [16];

  typedef struct {
    logic          rs;
    logic          av, awe;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv, bwe;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ea, eb;
    int            ec;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic av, input logic awe,
                              input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic bv, input logic bwe,
                              input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic ea, input logic eb, input int ec);
    vec_t v;
    v.rs = rs; v.av = av; v.awe = awe; v.aa = aa; v.ad = ad;
    v.bv = bv; v.bwe = bwe; v.ba = ba; v.bd = bd;
    v.ea = ea; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation and arrive on time.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        logic          v;
        logic [DW-1:0] d;
        v = (p == 0) ? rsp_a_valid : rsp_b_valid;
        d = (p == 0) ? rsp_a_rdata : rsp_b_rdata;
        while (q[p].size() > 0 && q[p][0].due < cyc) begin
          total++;
          bad++;
          $display("FAIL rsp_missing port=%0d cycle=%0d: actual=none required=%0h", p, cyc, q[p][0].d);
          void'(q[p].pop_front());
        end
        if (v) begin
          if (q[p].size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected port=%0d cycle=%0d: actual=%0h required=none", p, cyc, d);
          end else begin
            exp_t e;
            e = q[p].pop_front();
            chk($sformatf("rsp_data_%0d", p), {24'h0, d}, {24'h0, e.d});
            chk($sformatf("rsp_cycle_%0d", p), cyc, e.due);
          end
        end
      end
    end
  end

  task automatic apply(input vec_t v);
    logic wa, ra, wb, rb;
    rst         = v.rs;
    req_a_valid = v.av; req_a_we = v.awe; req_a_addr = v.aa; req_a_wdata = v.ad;
    req_b_valid = v.bv; req_b_we = v.bwe; req_b_addr = v.ba; req_b_wdata = v.bd;
    if (!v.rs) begin
      q[0].delete();
      q[1].delete();
    end
    @(negedge clk);
    chk("ready_a", {31'h0, req_a_ready}, {31'h0, v.ea});
    chk("ready_b", {31'h0, req_b_ready}, {31'h0, v.eb});
    chk("coll_cnt", {28'h0, collision_cnt}, v.ec);
    wa = v.av & v.ea &  v.awe;
    ra = v.av & v.ea & ~v.awe;
    wb = v.bv & v.eb &  v.bwe;
    rb = v.bv & v.eb & ~v.bwe;
    chk("ram_we_a", {31'h0, ram_we_a}, {31'h0, wa});
    chk("ram_re_a", {31'h0, ram_re_a}, {31'h0, ra});
    chk("ram_we_b", {31'h0, ram_we_b}, {31'h0, wb});
    chk("ram_re_b", {31'h0, ram_re_b}, {31'h0, rb});
    if (wa | ra) chk("ram_addr_a", {28'h0, ram_addr_a}, {28'h0, v.aa});
    if (wb | rb) chk("ram_addr_b", {28'h0, ram_addr_b}, {28'h0, v.ba});
    if (wa) chk("ram_din_a", {24'h0, ram_din_a}, {24'h0, v.ad});
    if (wb) chk("ram_din_b", {24'h0, ram_din_b}, {24'h0, v.bd});
    if (!v.rs) begin
      chk("rsp_a_valid_rst", {31'h0, rsp_a_valid}, 32'h0);
      chk("rsp_b_valid_rst", {31'h0, rsp_b_valid}, 32'h0);
    end
    if (ra) q[0].push_back('{d: ref_mem[v.aa], due: cyc + 2});
    if (rb) q[1].push_back('{d: ref_mem[v.ba], due: cyc + 2});
    if (wa) ref_mem[v.aa] = v.ad;
    if (wb) ref_mem[v.ba] = v.bd;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [27];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b0;
    req_a_valid = 1'b0; req_a_we = 1'b0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 1'b0; req_b_we = 1'b0; req_b_addr = '0; req_b_wdata = '0;

    //            rs av awe aa    ad     bv bwe ba    bd     ea eb cnt
    // reset held with both ports colliding
    tbl[0]  = mk(0, 1, 1, 4'h5, 8'h99, 1, 1, 4'h5, 8'h77, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 4'h5, 8'h99, 1, 1, 4'h5, 8'h77, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 4'h5, 8'h99, 1, 1, 4'h5, 8'h77, 0, 0, 0);
    // parallel writes then parallel reads
    tbl[3]  = mk(1, 1, 1, 4'hA, 8'h01, 1, 1, 4'hF, 8'h02, 1, 1, 0);
    tbl[4]  = mk(1, 1, 0, 4'hA, 8'h00, 1, 0, 4'hF, 8'h00, 1, 1, 0);
    // write/write hazard: A first, B one cycle later, read sees B's data
    tbl[5]  = mk(1, 1, 1, 4'h3, 8'h11, 1, 1, 4'h3, 8'h22, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 4'h0, 8'h00, 1, 1, 4'h3, 8'h22, 1, 1, 1);
    tbl[7]  = mk(1, 1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 1);
    tbl[8]  = mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 1);
    tbl[9]  = mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 1);
    // reset again so priority restarts at A
    tbl[10] = mk(0, 1, 1, 4'h5, 8'h99, 1, 1, 4'h5, 8'h77, 0, 0, 0);
    tbl[11] = mk(0, 1, 1, 4'h5, 8'h99, 1, 1, 4'h5, 8'h77, 0, 0, 0);
    tbl[12] = mk(0, 1, 1, 4'h5, 8'h99, 1, 1, 4'h5, 8'h77, 0, 0, 0);
    // persistent write/read hazard @5: grants A, B, A, B
    tbl[13] = mk(1, 1, 1, 4'h5, 8'h31, 1, 0, 4'h5, 8'h00, 1, 0, 0);
    tbl[14] = mk(1, 1, 1, 4'h5, 8'h32, 1, 0, 4'h5, 8'h00, 0, 1, 1);
    tbl[15] = mk(1, 1, 1, 4'h5, 8'h32, 1, 0, 4'h5, 8'h00, 1, 0, 2);
    tbl[16] = mk(1, 1, 1, 4'h5, 8'h33, 1, 0, 4'h5, 8'h00, 0, 1, 3);
    tbl[17] = mk(1, 1, 1, 4'h5, 8'h33, 0, 0, 4'h0, 8'h00, 1, 1, 4);
    tbl[18] = mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 4);
    // read/read same address is not a hazard
    tbl[19] = mk(1, 1, 1, 4'h7, 8'h5C, 0, 0, 4'h0, 8'h00, 1, 1, 4);
    tbl[20] = mk(1, 1, 0, 4'h7, 8'h00, 1, 0, 4'h7, 8'h00, 1, 1, 4);
    // write then read on consecutive cycles returns the new data
    tbl[21] = mk(1, 0, 0, 4'h0, 8'h00, 1, 1, 4'h9, 8'h6E, 1, 1, 4);
    tbl[22] = mk(1, 1, 0, 4'h9, 8'h00, 1, 0, 4'h9, 8'h00, 1, 1, 4);
    // back-to-back reads on both ports
    tbl[23] = mk(1, 1, 0, 4'hA, 8'h00, 1, 0, 4'h3, 8'h00, 1, 1, 4);
    tbl[24] = mk(1, 1, 0, 4'hF, 8'h00, 1, 0, 4'h5, 8'h00, 1, 1, 4);
    tbl[25] = mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 4);
    tbl[26] = mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 4);

    for (int i = 0; i < 27; i++) apply(tbl[i]);

    // Counter saturation: persistent write/write hazards, priority keeps alternating.
    for (int k = 0; k < 15; k++) begin
      int ec;
      ec = (4 + k > 15) ? 15 : 4 + k;
      apply(mk(1, 1, 1, 4'hC, 8'(8'h40 + k), 1, 1, 4'hC, 8'(8'h80 + k),
               (k % 2) == 0, (k % 2) == 1, ec));
    end
    apply(mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 15));
    apply(mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 15));

    // Mid-flight reset: accepted read must never produce a response.
    apply(mk(1, 1, 0, 4'hA, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 15));
    apply(mk(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 0));
    apply(mk(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      apply(mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 0));
    // priority back at A after reset
    apply(mk(1, 1, 1, 4'hD, 8'h44, 1, 1, 4'hD, 8'h55, 1, 0, 0));
    apply(mk(1, 0, 0, 4'h0, 8'h00, 1, 1, 4'hD, 8'h55, 1, 1, 1));
    apply(mk(1, 1, 0, 4'hD, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 1));
    for (int k = 0; k < 3; k++)
      apply(mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 1));

    chk("pending_a_left", q[0].size(), 0);
    chk("pending_b_left", q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
